spi_sensor_arbiter: RTL and testbench

- Parametrised successor to the single-sensor SPI test top.
- Lets NUM_SENSORS per-sensor BNO085 controllers share one spi_master.
- Round-robin arbitration, per-channel chip-select sequencing with setup and hold gaps, a transaction watchdog, and status outputs for LEDs.
- Sits between the sensor controllers and spi_master; the top level muxes spi_master inputs using sel.

---
 rtl/spi_sensor_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_sensor_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sensor_arbiter.sv
// -----------------------------------------------------------------------------
// spi_sensor_arbiter
//
// Shares one spi_master between NUM_SENSORS sensor controllers. Requests are
// served round-robin. Each transaction is framed by a per-channel chip select
// with a setup gap before the grant and a hold gap after the bus goes idle.
// A watchdog cuts off a grant that never sees its done pulse.
//
// Optional feature: define ARB_GRANT_STATS_EN to add the grant_count output,
// one 16-bit saturating grant counter per channel.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   req[N]         per-channel request level, held for the whole transaction
//   done[N]        per-channel single-cycle end-of-transaction pulse
//   spi_busy       spi_master busy flag
//   grant[N]       one-hot grant; owner may drive spi_master only while high
//   cs_n[N]        active-low chip selects, at most one low at a time
//   sel            index of the owning channel for the top-level mux
//   active         high whenever any cs_n is low
//   timeout_err[N] sticky per-channel watchdog flag
//   led_heartbeat  free-running counter bit HEARTBEAT_BIT
//   grant_count    (ARB_GRANT_STATS_EN only) 16 bits per channel, slice i = ch i
//
// Handshake: a client raises req[i] and holds it. The arbiter lowers cs_n[i],
// waits the setup gap, then raises grant[i]. The client owns spi_master while
// grant[i] is high and ends the transaction with a one-cycle done[i] pulse;
// grant[i] drops on the following cycle. Dropping req[i] before the grant
// cancels the request cleanly. A req still high after done is a new request.
// -----------------------------------------------------------------------------
module spi_sensor_arbiter #(
  parameter int NUM_SENSORS     = 2,
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_HOLD_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int HEARTBEAT_BIT   = 21,
  localparam int SEL_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] req,
  input  logic [NUM_SENSORS-1:0] done,
  input  logic                   spi_busy,
  output logic [NUM_SENSORS-1:0] grant,
  output logic [NUM_SENSORS-1:0] cs_n,
  output logic [SEL_W-1:0]       sel,
  output logic                   active,
  output logic [NUM_SENSORS-1:0] timeout_err,
  output logic                   led_heartbeat
`ifdef ARB_GRANT_STATS_EN
  ,
  output logic [NUM_SENSORS*16-1:0] grant_count
`endif
);

  localparam int CNT_MAX_A = (TIMEOUT_CYCLES > CS_SETUP_CYCLES) ? TIMEOUT_CYCLES : CS_SETUP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CS_HOLD_CYCLES) ? CNT_MAX_A : CS_HOLD_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_GRANTED,
    S_DRAIN,
    S_CS_HOLD,
    S_GAP
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] grant_q, grant_d;
  logic [NUM_SENSORS-1:0] cs_n_q, cs_n_d;
  logic                   active_q, active_d;
  logic [NUM_SENSORS-1:0] terr_q, terr_d;
  logic [HEARTBEAT_BIT:0] hb_q, hb_d;

  // Round-robin pick: scan from ptr_q downwards in offset so that the
  // smallest offset from the pointer is the last (winning) assignment.
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] scan_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      scan_idx = SEL_W'((int'(ptr_q) + i) % NUM_SENSORS);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  logic [SEL_W-1:0] ptr_next;
  assign ptr_next = (int'(sel_q) == NUM_SENSORS - 1) ? '0 : sel_q + SEL_W'(1);

  logic do_release;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    cs_n_d     = cs_n_q;
    active_d   = active_q;
    terr_d     = terr_q;
    do_release = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          sel_d    = pick_idx;
          cs_n_d   = ~(NUM_SENSORS'(1) << pick_idx);
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (!req[sel_q]) begin
          // Client withdrew before the grant: close the frame, no error.
          cnt_d   = '0;
          state_d = S_CS_HOLD;
        end else if (cnt_q == SETUP_LAST) begin
          grant_d = NUM_SENSORS'(1) << sel_q;
          cnt_d   = '0;
          state_d = S_GRANTED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GRANTED: begin
        // done is checked first so a simultaneous timeout raises no error.
        if (done[sel_q]) begin
          grant_d = '0;
          state_d = S_DRAIN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          grant_d        = '0;
          terr_d[sel_q]  = 1'b1;
          state_d        = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        // The first cycle seen with spi_busy low already counts as a hold
        // cycle, so an idle master costs no extra drain time.
        if (!spi_busy) begin
          if (CS_HOLD_CYCLES == 1) begin
            do_release = 1'b1;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_CS_HOLD;
          end
        end
      end

      S_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          do_release = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_release) begin
      cs_n_d   = '1;
      active_d = 1'b0;
      ptr_d    = ptr_next;
      cnt_d    = '0;
      state_d  = S_GAP;
    end
  end

  assign hb_d = hb_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      cs_n_q   <= '1;
      active_q <= 1'b0;
      terr_q   <= '0;
      hb_q     <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      cs_n_q   <= cs_n_d;
      active_q <= active_d;
      terr_q   <= terr_d;
      hb_q     <= hb_d;
    end
  end

  assign grant         = grant_q;
  assign cs_n          = cs_n_q;
  assign sel           = sel_q;
  assign active        = active_q;
  assign timeout_err   = terr_q;
  assign led_heartbeat = hb_q[HEARTBEAT_BIT];

`ifdef ARB_GRANT_STATS_EN
  logic [NUM_SENSORS*16-1:0] gcnt_q, gcnt_d;

  // A grant rising edge is visible one cycle early as grant_d & ~grant_q.
  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (grant_d[i] && !grant_q[i] && (gcnt_q[i*16 +: 16] != 16'hFFFF)) begin
        gcnt_d[i*16 +: 16] = gcnt_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign grant_count = gcnt_q;
`endif

endmodule

// File: tb/tb_spi_sensor_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_sensor_arbiter
//
// Directed bench for spi_sensor_arbiter with NUM_SENSORS=2, setup/hold of 4,
// TIMEOUT_CYCLES=20 and HEARTBEAT_BIT=3. A table of transactions gives the
// request pattern, client timing and the hand-computed owner, setup latency,
// grant length, cs hold length, idle wait and error flags. Hand-written
// sequences cover the setup abort and reset in the middle of a grant.
// -----------------------------------------------------------------------------
module tb_spi_sensor_arbiter;

  localparam int N = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic         spi_busy;
  logic [N-1:0] grant;
  logic [N-1:0] cs_n;
  logic [0:0]   sel;
  logic         active;
  logic [N-1:0] timeout_err;
  logic         led_heartbeat;
`ifdef ARB_GRANT_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  spi_sensor_arbiter #(
    .NUM_SENSORS     (N),
    .CS_SETUP_CYCLES (4),
    .CS_HOLD_CYCLES  (4),
    .TIMEOUT_CYCLES  (20),
    .HEARTBEAT_BIT   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .done          (done),
    .spi_busy      (spi_busy),
    .grant         (grant),
    .cs_n          (cs_n),
    .sel           (sel),
    .active        (active),
    .timeout_err   (timeout_err),
    .led_heartbeat (led_heartbeat)
`ifdef ARB_GRANT_STATS_EN
    ,
    .grant_count   (grant_count)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Structural invariants, every cycle.
  always @(negedge clk) begin
    logic [N-1:0] cs_low;
    bit ok;
    cs_low = ~cs_n;
    ok = ($countones(cs_low) <= 1) && ($countones(grant) <= 1) &&
         ((grant & cs_n) == '0) && (active == (cs_low != '0));
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL invariant @%0t: cs_n=%b grant=%b active=%b expected one-hot cs, grant under cs, active=|~cs_n",
               $time, cs_n, grant, active);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [1:0] req;
    int         done_dly;    // grant cycle on which done is pulsed, -1 = never
    int         busy_extra;  // cycles spi_busy stays high after done
    logic [1:0] req_after;   // req level once grant has dropped
    int         exp_ch;
    int         exp_setup;
    int         exp_glen;
    int         exp_hold;
    int         exp_wait;
    logic [1:0] exp_terr;
  } vec_t;

  vec_t vecs[13];

  // ---------------------------------------------------------------- driver
  task automatic run_txn(input vec_t v, output int ch, output int sel_seen,
                         output int setup_lat, output int glen,
                         output int hold, output int wait_c);
    logic [N-1:0] ch_mask;
    bit got;
    ch = -1; sel_seen = -1; setup_lat = -1; glen = 0; hold = 0; wait_c = -1;
    req = v.req; done = '0; spi_busy = 1'b0;

    got = 1'b0;
    for (int i = 1; i <= 50 && !got; i++) begin
      @(negedge clk);
      if (cs_n != 2'b11) begin
        got = 1'b1;
        wait_c = i;
      end
    end
    if (!got) return;
    ch       = (cs_n[0] == 1'b0) ? 0 : 1;
    sel_seen = int'(sel);
    ch_mask  = 2'(1 << ch);

    got = 1'b0;
    for (int i = 1; i <= 50 && !got; i++) begin
      @(negedge clk);
      if ((grant & ch_mask) != '0) begin
        got = 1'b1;
        setup_lat = i;
      end
    end
    if (!got) return;

    glen = 1;
    for (int j = 0; j < 100; j++) begin
      if (v.done_dly == glen) begin
        done     = ch_mask;
        spi_busy = (v.busy_extra > 0);
      end
      @(negedge clk);
      done = '0;
      if ((grant & ch_mask) == '0) break;
      glen++;
    end
    req = v.req_after;

    for (int k = 1; k <= 40; k++) begin
      if ((cs_n & ch_mask) != '0) break;
      hold++;
      if (k == v.busy_extra + 1) spi_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic apply_vec(input int i);
    int ch, sel_seen, setup_lat, glen, hold, wait_c;
    logic [1:0] exp_ch;
    exp_q.push_back(2'(vecs[i].exp_ch));
    run_txn(vecs[i], ch, sel_seen, setup_lat, glen, hold, wait_c);
    exp_ch = exp_q.pop_front();
    check($sformatf("v%0d_owner", i), ch, int'(exp_ch));
    check($sformatf("v%0d_sel", i), sel_seen, int'(exp_ch));
    check($sformatf("v%0d_wait", i), wait_c, vecs[i].exp_wait);
    check($sformatf("v%0d_setup", i), setup_lat, vecs[i].exp_setup);
    check($sformatf("v%0d_grant_len", i), glen, vecs[i].exp_glen);
    check($sformatf("v%0d_cs_hold", i), hold, vecs[i].exp_hold);
    check($sformatf("v%0d_timeout_err", i), int'(timeout_err), int'(vecs[i].exp_terr));
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    //               req    dd  be  after  ch su  gl hold wait terr
    vecs[0]  = '{2'b01, 10, 0, 2'b00, 0, 4, 10, 4,  1, 2'b00};
    vecs[1]  = '{2'b11,  5, 0, 2'b11, 1, 4,  5, 4,  2, 2'b00};
    vecs[2]  = '{2'b11,  5, 0, 2'b11, 0, 4,  5, 4,  2, 2'b00};
    vecs[3]  = '{2'b11,  5, 0, 2'b11, 1, 4,  5, 4,  2, 2'b00};
    vecs[4]  = '{2'b11,  5, 0, 2'b11, 0, 4,  5, 4,  2, 2'b00};
    vecs[5]  = '{2'b11, -1, 0, 2'b11, 1, 4, 20, 4,  2, 2'b10};
    vecs[6]  = '{2'b11,  3, 0, 2'b00, 0, 4,  3, 4,  2, 2'b10};
    vecs[7]  = '{2'b01,  6, 7, 2'b00, 0, 4,  6, 11, 2, 2'b10};
    vecs[8]  = '{2'b10,  2, 0, 2'b00, 1, 4,  2, 4,  2, 2'b10};
    vecs[9]  = '{2'b11,  4, 0, 2'b01, 0, 4,  4, 4,  1, 2'b00};
    vecs[10] = '{2'b01,  4, 0, 2'b01, 0, 4,  4, 4,  2, 2'b00};
    vecs[11] = '{2'b01,  4, 0, 2'b00, 0, 4,  4, 4,  2, 2'b00};
    vecs[12] = '{2'b10,  4, 0, 2'b00, 1, 4,  4, 4,  2, 2'b00};

    rst = 1'b1; req = '0; done = '0; spi_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", int'(grant), 0);
    check("rst_cs_n", int'(cs_n), 3);
    check("rst_sel", int'(sel), 0);
    check("rst_active", int'(active), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_heartbeat", int'(led_heartbeat), 0);
    rst = 1'b0;

    // Heartbeat counter bit 3 sets on the eighth clock after reset.
    repeat (7) @(negedge clk);
    check("heartbeat_7", int'(led_heartbeat), 0);
    @(negedge clk);
    check("heartbeat_8", int'(led_heartbeat), 1);

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Request withdrawn during setup: no grant, no error, normal hold.
    begin
      bit got, saw_grant;
      int hold;
      req = 2'b01; got = 1'b0; saw_grant = 1'b0; hold = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (cs_n[0] == 1'b0) got = 1'b1;
      end
      check("abort_cs_fall", int'(got), 1);
      req = 2'b00;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (grant != '0) saw_grant = 1'b1;
        if (cs_n[0] == 1'b1) break;
        hold++;
      end
      check("abort_hold", hold, 4);
      check("abort_no_grant", int'(saw_grant), 0);
      check("abort_timeout_err", int'(timeout_err), 2);
    end

    // Reset while granted: everything releases at once, before any clock.
    begin
      bit got;
      req = 2'b01; got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        if (grant[0]) got = 1'b1;
      end
      check("midrst_granted", int'(got), 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_cs_n", int'(cs_n), 3);
      check("midrst_grant", int'(grant), 0);
      check("midrst_timeout_err", int'(timeout_err), 0);
      check("midrst_active", int'(active), 0);
      check("midrst_sel", int'(sel), 0);
      req = '0;
      @(negedge clk);
      rst = 1'b0;
    end

    for (int i = 9; i < 13; i++) apply_vec(i);

`ifdef ARB_GRANT_STATS_EN
    check("grant_count_ch0", int'(grant_count[15:0]), 3);
    check("grant_count_ch1", int'(grant_count[31:16]), 1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
